fft_sample_feeder: RTL and testbench

- Source end of the FFT_N sample-load interface. Supplies the `in` word, `start` strobe and `inc` advance for frame loading.
- Captures a continuous 32-bit sample stream into a 2x256-word ping-pong buffer.
- Once a bank is full and the FFT reports ready, pulses start and serves the 256 words in order, advancing once per inc pulse.
- Sits between the ADC/sample front end and FFT_N.

---
 rtl/fft_sample_feeder.sv | 208 ++++++++++++++++++++
 tb/tb_fft_sample_feeder.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/fft_sample_feeder.sv
// fft_sample_feeder: captures a continuous sample stream into a 2-bank
// ping-pong buffer and serves each full bank to FFT_N as one frame.
// Words are presented on fft_in and advance on each rising edge of fft_inc.
// Optional build macro FEEDER_OVERWRITE_EN: a stalled writer discards its
// queued full frame and refills that bank instead of dropping samples.
module fft_sample_feeder #(
    parameter int DW    = 32,
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] sample_in,
    input  logic          sample_valid,
    input  logic          fft_ready,
    input  logic          fft_valid,
    input  logic          fft_inc,
    output logic          fft_start,
    output logic [DW-1:0] fft_in,
    output logic          overrun,
    output logic [15:0]   drop_cnt,
    output logic          busy
);

    localparam logic [1:0] B_EMPTY   = 2'd0;
    localparam logic [1:0] B_FILLING = 2'd1;
    localparam logic [1:0] B_FULL    = 2'd2;
    localparam logic [1:0] B_READING = 2'd3;

    typedef enum logic [2:0] {IDLE, PRELOAD, ARM, START, FEED, DRAIN} state_t;

    logic [DW-1:0]   mem [0:2*DEPTH-1];
    logic [DW-1:0]   rd_data_p1;
    logic [1:0][1:0] bstat;
    logic [AW-1:0]   wptr;
    logic            wbank;
    logic            stall;
    logic            last_full;
    logic            wr_en;
    logic            wr_last;
    logic            release_w;
    logic            ovw;
    logic            drop;
    logic            mem_we;
    logic [AW:0]     mem_waddr;

    state_t          state, state_nx;
    logic            rbank, rbank_nx;
    logic [AW-1:0]   rptr, rptr_nx;
    logic            pick_en;
    logic            adv, adv_p1;
    logic            inc_r;
    logic            inc_edge;

    function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    // Write-side decode: normal write, stall release, overwrite of a queued frame, drop
    always_comb begin
        wr_en     = sample_valid && !stall;
        wr_last   = wr_en && (wptr == AW'(DEPTH - 1));
        release_w = stall && (bstat[~wbank] == B_EMPTY);
`ifdef FEEDER_OVERWRITE_EN
        ovw       = stall && sample_valid && !release_w &&
                    (bstat[wbank] == B_FULL) && (bstat[~wbank] == B_READING);
`else
        ovw       = 1'b0;
`endif
        drop      = stall && sample_valid && !ovw;
        mem_we    = wr_en || ovw;
        mem_waddr = {wbank, (ovw ? {AW{1'b0}} : wptr)};
    end

    // Sample memory write port
    always_ff @(posedge clk) begin
        if (mem_we)
            mem[mem_waddr] <= sample_in;
    end

    // Sample memory read port; address follows the next read pointer so the
    // registered word always matches the current rbank/rptr
    always_ff @(posedge clk) begin
        rd_data_p1 <= mem[{rbank_nx, rptr_nx}];
    end

    // Write pointer, bank select, stall and drop accounting
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr      <= '0;
            wbank     <= 1'b0;
            stall     <= 1'b0;
            last_full <= 1'b0;
            drop_cnt  <= '0;
            overrun   <= 1'b0;
        end else begin
            if (ovw) begin
                wptr  <= AW'(1);
                stall <= 1'b0;
            end else if (release_w) begin
                wbank <= ~wbank;
                stall <= 1'b0;
            end else if (wr_en) begin
                wptr <= wptr + 1'b1;
                if (wr_last) begin
                    last_full <= wbank;
                    if (bstat[~wbank] == B_EMPTY)
                        wbank <= ~wbank;
                    else
                        stall <= 1'b1;
                end
            end
            if (drop) begin
                drop_cnt <= sat_add(drop_cnt, 16'd1);
                overrun  <= 1'b1;
            end else if (ovw) begin
                drop_cnt <= sat_add(drop_cnt, 16'(DEPTH));
                overrun  <= 1'b1;
            end
        end
    end

    // Per-bank status, updated by both the write side and the read FSM
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bstat <= {B_EMPTY, B_EMPTY};
        end else begin
            if (ovw)
                bstat[wbank] <= B_FILLING;
            else if (wr_en)
                bstat[wbank] <= wr_last ? B_FULL : B_FILLING;
            if (pick_en)
                bstat[rbank_nx] <= B_READING;
            if ((state == DRAIN) && fft_valid)
                bstat[rbank] <= B_EMPTY;
        end
    end

    // Read FSM state register with read pointer, inc history and output word
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            rbank  <= 1'b0;
            rptr   <= '0;
            inc_r  <= 1'b0;
            adv_p1 <= 1'b0;
            fft_in <= '0;
        end else begin
            state  <= state_nx;
            rbank  <= rbank_nx;
            rptr   <= rptr_nx;
            inc_r  <= fft_inc;
            adv_p1 <= adv;
            if ((state == PRELOAD) || adv_p1)
                fft_in <= rd_data_p1;
        end
    end

    // Read FSM next-state: bank selection, start handshake, per-edge advance
    always_comb begin
        state_nx = state;
        rbank_nx = rbank;
        rptr_nx  = rptr;
        pick_en  = 1'b0;
        adv      = 1'b0;
        inc_edge = fft_inc && !inc_r;
        case (state)
            IDLE: begin
                if ((bstat[0] == B_FULL) || (bstat[1] == B_FULL)) begin
                    pick_en  = 1'b1;
                    rptr_nx  = '0;
                    state_nx = PRELOAD;
                    if ((bstat[0] == B_FULL) && (bstat[1] == B_FULL))
                        rbank_nx = ~last_full;
                    else
                        rbank_nx = (bstat[1] == B_FULL);
                end
            end
            PRELOAD: state_nx = ARM;
            ARM:     if (fft_ready) state_nx = START;
            START: begin
                rptr_nx  = '0;
                state_nx = FEED;
            end
            FEED: begin
                if (inc_edge) begin
                    if (rptr == AW'(DEPTH - 1)) begin
                        state_nx = DRAIN;
                    end else begin
                        rptr_nx = rptr + 1'b1;
                        adv     = 1'b1;
                    end
                end
            end
            DRAIN:   if (fft_valid) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Read FSM outputs
    always_comb begin
        fft_start = (state == START);
        busy      = (state != IDLE);
    end

endmodule

// File: tb/tb_fft_sample_feeder.sv
// Directed bench for fft_sample_feeder: basic frame, ping-pong, overrun,
// held inc, spurious strobes and asynchronous reset mid-frame.
module tb_fft_sample_feeder;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] sample_in;
    logic        sample_valid;
    logic        fft_ready;
    logic        fft_valid;
    logic        fft_inc;
    logic        fft_start;
    logic [31:0] fft_in;
    logic        overrun;
    logic [15:0] drop_cnt;
    logic        busy;

    int          n_chk = 0;
    int          n_pass = 0;
    int          start_cnt = 0;
    logic [31:0] start_word = '0;

    fft_sample_feeder dut (
        .clk          (clk),
        .rst          (rst),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .fft_ready    (fft_ready),
        .fft_valid    (fft_valid),
        .fft_inc      (fft_inc),
        .fft_start    (fft_start),
        .fft_in       (fft_in),
        .overrun      (overrun),
        .drop_cnt     (drop_cnt),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Record every start pulse and the word presented with it
    always @(negedge clk) begin
        if (fft_start) begin
            start_cnt++;
            start_word = fft_in;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic stream(input int first, input int n, input int ready_at);
        for (int i = 0; i < n; i++) begin
            sample_valid = 1'b1;
            sample_in    = first + i;
            if (i == ready_at) fft_ready = 1'b1;
            tick();
        end
        sample_valid = 1'b0;
    endtask

    task automatic wait_start(input int prev, input logic [31:0] exp_word, input string tag);
        int t;
        t = 0;
        while (start_cnt == prev && t < 200) begin
            tick();
            t++;
        end
        check({tag, " start count"}, start_cnt, prev + 1);
        check({tag, " start word"}, start_word, exp_word);
        check({tag, " start width"}, {31'd0, fft_start}, 32'd0);
    endtask

    task automatic serve(input logic [31:0] base, input int hold, input bit spur, input string tag);
        for (int k = 1; k <= 256; k++) begin
            fft_inc = 1'b1;
            repeat (hold) tick();
            fft_inc = 1'b0;
            repeat (8 - hold) tick();
            if (k < 256)
                check({tag, " word"}, fft_in, base + k);
            else begin
                check({tag, " last word held"}, fft_in, base + 255);
                check({tag, " busy in drain"}, {31'd0, busy}, 32'd1);
            end
            if (spur && k == 10) begin
                fft_valid = 1'b1;
                tick();
                fft_valid = 1'b0;
                tick();
                check({tag, " spurious valid word"}, fft_in, base + 10);
                check({tag, " spurious valid busy"}, {31'd0, busy}, 32'd1);
            end
        end
        fft_valid = 1'b1;
        tick();
        fft_valid = 1'b0;
        check({tag, " idle after valid"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        tick();
    endtask

    initial begin
        rst          = 1'b0;
        sample_in    = '0;
        sample_valid = 1'b0;
        fft_ready    = 1'b0;
        fft_valid    = 1'b0;
        fft_inc      = 1'b0;
        repeat (2) tick();
        check("reset fft_start", {31'd0, fft_start}, 32'd0);
        check("reset fft_in", fft_in, 32'd0);
        check("reset overrun", {31'd0, overrun}, 32'd0);
        check("reset drop_cnt", {16'd0, drop_cnt}, 32'd0);
        check("reset busy", {31'd0, busy}, 32'd0);
        rst = 1'b1;
        tick();

        // Basic frame with a spurious fft_valid during FEED
        fft_ready = 1'b1;
        stream(0, 256, 0);
        wait_start(start_cnt, 32'd0, "basic");
        serve(32'd0, 1, 1'b1, "basic");

        // Spurious inc while IDLE
        fft_inc = 1'b1;
        repeat (2) tick();
        fft_inc = 1'b0;
        repeat (2) tick();
        check("idle inc busy", {31'd0, busy}, 32'd0);
        check("idle inc word", fft_in, 32'd255);

        // Ping-pong: 512 samples, ready raised at sample 300
        do_reset();
        fft_ready = 1'b0;
        begin
            int s0;
            s0 = start_cnt;
            stream(0, 512, 300);
            check("pingpong one start", start_cnt, s0 + 1);
            check("pingpong first word", start_word, 32'd0);
            serve(32'd0, 1, 1'b0, "pp frame0");
            wait_start(s0 + 1, 32'd256, "pp frame1");
            serve(32'd256, 1, 1'b0, "pp frame1");
            check("pingpong drop_cnt", {16'd0, drop_cnt}, 32'd0);
            check("pingpong overrun", {31'd0, overrun}, 32'd0);
        end

        // Overrun: 768 samples with ready held low; second frame with held inc
        do_reset();
        fft_ready = 1'b0;
        stream(0, 768, 1000);
        check("overrun drop_cnt", {16'd0, drop_cnt}, 32'd256);
        check("overrun flag", {31'd0, overrun}, 32'd1);
        fft_ready = 1'b1;
        wait_start(start_cnt, 32'd0, "ovr frame0");
        serve(32'd0, 1, 1'b0, "ovr frame0");
`ifdef FEEDER_OVERWRITE_EN
        wait_start(start_cnt, 32'd512, "ovr frame1");
        serve(32'd512, 4, 1'b0, "ovr frame1 held");
`else
        wait_start(start_cnt, 32'd256, "ovr frame1");
        serve(32'd256, 4, 1'b0, "ovr frame1 held");
`endif
        check("overrun drop_cnt after", {16'd0, drop_cnt}, 32'd256);

        // Asynchronous reset in the middle of FEED
        stream(32'h1000, 256, 0);
        wait_start(start_cnt, 32'h1000, "rst frame");
        for (int k = 0; k < 3; k++) begin
            fft_inc = 1'b1;
            tick();
            fft_inc = 1'b0;
            repeat (7) tick();
        end
        check("pre-reset word", fft_in, 32'h1003);
        check("pre-reset busy", {31'd0, busy}, 32'd1);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("async fft_in", fft_in, 32'd0);
        check("async fft_start", {31'd0, fft_start}, 32'd0);
        check("async overrun", {31'd0, overrun}, 32'd0);
        check("async drop_cnt", {16'd0, drop_cnt}, 32'd0);
        check("async busy", {31'd0, busy}, 32'd0);
        tick();
        rst = 1'b1;
        tick();
        check("post-reset idle", {31'd0, busy}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
